uart_rx_frame: RTL
==================

Name: uart_rx_frame

Overview:
- UART receiver that pairs with the design's existing UART transmitter and uses the same 8N1, LSB-first framing.
- Oversamples the serial line with the system clock and validates the start bit at mid-bit.
- Samples each data bit and the stop bit at mid-bit, then presents the byte with a one-cycle valid strobe.
- Used on the bench loopback and in a future host-to-chip command path feeding the save/data registers.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- BIT_RATE, 9600, serial baud rate.
- PAYLOAD_BITS, 8, data bits per frame.
- CYCLES_PER_BIT, CLK_HZ/BIT_RATE (derived localparam), clocks per bit; must be >= 4.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- uart_rx_en  input  1  receive enable; when low the block stays in IDLE.
- uart_rxd  input  1  asynchronous serial line; idle high.
- uart_rx_data  output  PAYLOAD_BITS  last received byte.
- uart_rx_valid  output  1  one-cycle strobe: uart_rx_data updated with a good frame.
- uart_rx_frame_err  output  1  one-cycle strobe: stop bit sampled low.
- uart_rx_busy  output  1  high while a frame is being received (any state except IDLE).

Behaviour:
- Reset values:
  - uart_rx_data = 0; uart_rx_valid = 0; uart_rx_frame_err = 0; uart_rx_busy = 0.
  - State = IDLE; synchronizer flops = 1.
- Input synchronization:
  - uart_rxd passes through a 2-flop synchronizer into rxd_s.
  - All decisions use rxd_s only.
- Counters:
  - cycle_cnt counts 0..CYCLES_PER_BIT-1.
  - bit_cnt counts 0..PAYLOAD_BITS-1.
  - Width of each counter is clog2 of its range.
- State IDLE:
  - cycle_cnt = 0.
  - If uart_rx_en = 1 and rxd_s = 0, go to START.
- State START:
  - Count to CYCLES_PER_BIT/2 - 1.
  - At that count, if rxd_s = 0, clear cycle_cnt and bit_cnt and go to DATA.
  - Otherwise (glitch) return to IDLE with no strobe.
- State DATA:
  - Count to CYCLES_PER_BIT-1, then sample rxd_s into the shift register, LSB first (shift right, new bit enters the MSB).
  - After sampling bit PAYLOAD_BITS-1, go to STOP.
  - Otherwise increment bit_cnt.
- State STOP:
  - Count to CYCLES_PER_BIT-1, then sample rxd_s.
  - If rxd_s = 1: load uart_rx_data from the shift register and pulse uart_rx_valid for 1 cycle.
  - If rxd_s = 0: pulse uart_rx_frame_err for 1 cycle; uart_rx_data is unchanged.
  - In both cases go to IDLE.
- Re-arm after STOP:
  - After a good frame, IDLE re-arms immediately, so back-to-back frames are accepted.
  - After a framing error, IDLE waits for rxd_s = 1 before re-arming; a break condition yields exactly one error strobe.
- Strobes:
  - uart_rx_valid and uart_rx_frame_err are never high together.
  - Both are registered and deassert on the next cycle.
- Data hold:
  - uart_rx_data holds its value until the next good frame.
  - No consumer handshake; an unread byte is overwritten.
- uart_rx_en deasserted:
  - Dropping mid-frame does not abort the frame; it completes normally.
  - Gating applies only to the IDLE to START transition.
- Latency:
  - From the falling edge on uart_rxd, 2 cycles of synchronizer delay, then start-bit detection.
  - uart_rx_valid rises 2 + CYCLES_PER_BIT/2 + (PAYLOAD_BITS+1)*CYCLES_PER_BIT cycles after that edge (±1).
- Reset mid-frame:
  - Asynchronously returns to IDLE and clears all outputs and counters.
  - The partial frame is discarded.

Test Plan:
All scenarios use CLK_HZ = 1_000_000 and BIT_RATE = 100_000, so CYCLES_PER_BIT = 10.
- Reset and idle: hold reset_n = 0, then release with uart_rxd = 1 for 200 cycles -> all outputs 0, busy 0, no strobes.
- Single frame: drive byte 0xA5, LSB first, 10 cycles per bit, stop = 1 -> exactly one uart_rx_valid pulse at about cycle 97 after the start edge; uart_rx_data = 0xA5; busy high throughout the frame.
- Back-to-back frames: send 0x00 then 0xFF with no idle gap -> two valid pulses, data 0x00 then 0xFF, no frame_err.
- Start glitch and enable gating:
  - uart_rxd low for 3 cycles, then high -> busy returns to 0, no strobe, uart_rx_data unchanged.
  - With uart_rx_en = 0, send 0x3C -> no activity.
- Framing error and break:
  - Send 0x55 with stop bit = 0 -> one uart_rx_frame_err pulse, no valid pulse, data unchanged.
  - Hold the line low for 50 more cycles -> no further strobes.
  - Release the line, then send 0x12 -> valid pulse with data 0x12.
- Reset mid-frame: assert reset_n = 0 during data bit 4 of 0xC3, release, then send 0x81 -> only the 0x81 valid pulse is seen.

Source files
------------

// File: rtl/uart_rx_frame.sv
// ----------------------------------------------------------------------------
// uart_rx_frame
//
// 8N1-style UART receiver, LSB first, matching the companion transmitter.
// The serial line is oversampled by the system clock. The start bit is
// validated at its midpoint. Each data bit and the stop bit are then sampled
// at their midpoints. A good frame loads uart_rx_data and pulses
// uart_rx_valid for one cycle. A low stop bit pulses uart_rx_frame_err for
// one cycle instead. After an error the receiver does not re-arm until the
// line has returned high, so a break condition produces only one error
// strobe.
//
// CYCLES_PER_BIT (CLK_HZ / BIT_RATE) must be at least 4, and PAYLOAD_BITS at
// least 2.
//
// Ports:
//   clk                system clock, rising edge
//   reset_n            asynchronous active-low reset
//   uart_rx_en         receive enable; gates only the IDLE -> START step
//   uart_rxd           asynchronous serial input, idle high
//   uart_rx_data       last good byte received; held until the next good frame
//   uart_rx_valid      one-cycle strobe: uart_rx_data was just updated
//   uart_rx_frame_err  one-cycle strobe: stop bit was sampled low
//   uart_rx_busy       high in every state except IDLE
// ----------------------------------------------------------------------------
module uart_rx_frame #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    uart_rx_en,
  input  logic                    uart_rxd,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_valid,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_busy
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int BW = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  // Terminal counts: mid start bit, end of a full bit, last payload bit.
  localparam logic [CW-1:0] HALF_LAST = CW'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CYCLES_PER_BIT - 1);
  localparam logic [BW-1:0] PAY_LAST  = BW'(PAYLOAD_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                  state, state_d;
  logic                    rxd_m, rxd_s;
  logic [CW-1:0]           cycle_cnt, cycle_d;
  logic [BW-1:0]           bit_cnt, bit_d;
  logic [PAYLOAD_BITS-1:0] shift, shift_d;
  logic [PAYLOAD_BITS-1:0] data_d;
  logic                    valid_d, err_d;
  // Set by a framing error; blocks re-arming until the line is seen high.
  logic                    brk_wait, brk_wait_d;

  // Two-flop synchronizer for the asynchronous serial input.
  // NOTE: these flops reset to 1, the idle line level, so leaving reset can
  // never be mistaken for a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= uart_rxd;
      rxd_s <= rxd_m;
    end
  end

  // State register.
  // NOTE: sequential state is updated only with non-blocking assignments, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // Next-state logic and datapath updates.
  // NOTE: every signal driven here is given a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state;
    cycle_d    = cycle_cnt;
    bit_d      = bit_cnt;
    shift_d    = shift;
    data_d     = uart_rx_data;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    brk_wait_d = brk_wait;

    unique case (state)
      IDLE: begin
        cycle_d = '0;
        if (rxd_s) brk_wait_d = 1'b0;
        if (uart_rx_en && !rxd_s && !brk_wait) state_d = START;
      end

      START: begin
        if (cycle_cnt == HALF_LAST) begin
          cycle_d = '0;
          if (!rxd_s) begin
            bit_d   = '0;
            state_d = DATA;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_d = IDLE;
          end
        end else begin
          cycle_d = cycle_cnt + CW'(1);
        end
      end

      DATA: begin
        if (cycle_cnt == BIT_LAST) begin
          cycle_d = '0;
          // LSB first: shift right, the newest bit enters at the MSB.
          shift_d = {rxd_s, shift[PAYLOAD_BITS-1:1]};
          if (bit_cnt == PAY_LAST) state_d = STOP;
          else                     bit_d   = bit_cnt + BW'(1);
        end else begin
          cycle_d = cycle_cnt + CW'(1);
        end
      end

      STOP: begin
        if (cycle_cnt == BIT_LAST) begin
          cycle_d = '0;
          state_d = IDLE;
          if (rxd_s) begin
            data_d  = shift;
            valid_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            brk_wait_d = 1'b1;
          end
        end else begin
          cycle_d = cycle_cnt + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered output strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt         <= '0;
      bit_cnt           <= '0;
      shift             <= '0;
      uart_rx_data      <= '0;
      uart_rx_valid     <= 1'b0;
      uart_rx_frame_err <= 1'b0;
      brk_wait          <= 1'b0;
    end else begin
      cycle_cnt         <= cycle_d;
      bit_cnt           <= bit_d;
      shift             <= shift_d;
      uart_rx_data      <= data_d;
      uart_rx_valid     <= valid_d;
      uart_rx_frame_err <= err_d;
      brk_wait          <= brk_wait_d;
    end
  end

  assign uart_rx_busy = (state != IDLE);

endmodule
